oddeven_arbiter: RTL and testbench

Shares one 3-bit odd/even counter between two requesters.
- Each requester asks for a burst of N counter steps in a chosen mode.
- The arbiter grants one requester at a time and clears the counter.
- It drives the counter's mode input K and a step enable for exactly N cycles, then signals completion.
- It sits between the control logic and the counter, which it drives through K, STEP and CNT_RST_N.

---
 rtl/oddeven_pkg.sv | 19 +
 rtl/oddeven_rr_pick.sv | 37 +++
 rtl/oddeven_arbiter.sv | 153 +++++++++++++++
 tb/tb_oddeven_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oddeven_pkg.sv
// Shared types and constants for the odd/even counter arbiter.
package oddeven_pkg;

  // Arbiter FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StClear = 2'd1,
    StRun   = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Default width of the burst-length inputs and the step counter.
  localparam int unsigned LEN_W_DEFAULT = 4;

  // Requester indices.
  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/oddeven_rr_pick.sv
// Two-way requester picker.
// Build option: define ODDEVEN_ARB_PRIO_EN for fixed priority (requester 0 wins ties);
// otherwise ties are resolved by the round-robin pointer.
module oddeven_rr_pick
  import oddeven_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic ptr_i,     // requester favoured on a tie
  output logic winner_o,
  output logic valid_o
);

`ifdef ODDEVEN_ARB_PRIO_EN
  // Pointer has no effect under fixed priority.
  logic unused_ptr;
  assign unused_ptr = ptr_i;
`endif

  // Choose the winning requester from the current requests.
  always_comb begin
    valid_o  = req0_i | req1_i;
    winner_o = REQ_ID0;
`ifdef ODDEVEN_ARB_PRIO_EN
    if (!req0_i && req1_i) begin
      winner_o = REQ_ID1;
    end
`else
    if (req0_i && req1_i) begin
      winner_o = ptr_i;
    end else if (req1_i) begin
      winner_o = REQ_ID1;
    end
`endif
  end

endmodule

// File: rtl/oddeven_arbiter.sv
// Arbitrates two requesters for a shared 3-bit odd/even counter. The winner gets a counter
// clear, then exactly LEN step-enable cycles in its latched mode, then a DONE pulse.
// Build option: ODDEVEN_ARB_PRIO_EN selects fixed priority instead of round-robin.
module oddeven_arbiter
  import oddeven_pkg::*;
#(
  parameter int unsigned LEN_W = LEN_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic             MODE0,
  input  logic [LEN_W-1:0] LEN0,
  input  logic             REQ1,
  input  logic             MODE1,
  input  logic [LEN_W-1:0] LEN1,
  output logic             GNT0,
  output logic             GNT1,
  output logic             DONE0,
  output logic             DONE1,
  output logic             K,
  output logic             STEP,
  output logic             CNT_RST_N,
  output logic             BUSY
);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             mode_q, mode_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] cnt_inc;
  logic             ptr_q, ptr_d;

  logic gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic done0_q, done0_d, done1_q, done1_d;
  logic k_q, k_d, step_q, step_d, cnt_rst_n_q, cnt_rst_n_d, busy_q, busy_d;

  logic pick_winner, pick_valid;
  logic owner_req;

  oddeven_rr_pick u_pick (
    .req0_i   (REQ0),
    .req1_i   (REQ1),
    .ptr_i    (ptr_q),
    .winner_o (pick_winner),
    .valid_o  (pick_valid)
  );

  assign owner_req = (owner_q == REQ_ID1) ? REQ1 : REQ0;
  assign cnt_inc   = cnt_q + LEN_W'(1);

  // Next-state logic; outputs are decoded from the next state so they come out of flops.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    mode_d  = mode_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          owner_d = pick_winner;
          mode_d  = (pick_winner == REQ_ID1) ? MODE1 : MODE0;
          len_d   = (pick_winner == REQ_ID1) ? LEN1 : LEN0;
          cnt_d   = '0;
          state_d = StClear;
        end
      end
      StClear: begin
        // A dropped request abandons the burst; the turn still passes on.
        if (!owner_req) begin
          state_d = StIdle;
          ptr_d   = ~owner_q;
        end else if (len_q == '0) begin
          state_d = StDone;
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        cnt_d = cnt_inc;
        if (!owner_req) begin
          state_d = StIdle;
          ptr_d   = ~owner_q;
        end else if (cnt_inc == len_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        ptr_d   = ~owner_q;
      end
      default: state_d = StIdle;
    endcase

    gnt0_d      = (state_d != StIdle) && (owner_d == REQ_ID0);
    gnt1_d      = (state_d != StIdle) && (owner_d == REQ_ID1);
    done0_d     = (state_d == StDone) && (owner_d == REQ_ID0);
    done1_d     = (state_d == StDone) && (owner_d == REQ_ID1);
    k_d         = (state_d != StIdle) ? mode_d : 1'b0;
    step_d      = (state_d == StRun);
    cnt_rst_n_d = (state_d != StClear);
    busy_d      = (state_d != StIdle);
  end

  // State and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      owner_q     <= REQ_ID0;
      mode_q      <= 1'b0;
      len_q       <= '0;
      cnt_q       <= '0;
      ptr_q       <= REQ_ID0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      k_q         <= 1'b0;
      step_q      <= 1'b0;
      cnt_rst_n_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      k_q         <= k_d;
      step_q      <= step_d;
      cnt_rst_n_q <= cnt_rst_n_d;
      busy_q      <= busy_d;
    end
  end

  assign GNT0      = gnt0_q;
  assign GNT1      = gnt1_q;
  assign DONE0     = done0_q;
  assign DONE1     = done1_q;
  assign K         = k_q;
  assign STEP      = step_q;
  assign CNT_RST_N = cnt_rst_n_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_oddeven_arbiter.sv
// Bench for oddeven_arbiter: the driver predicts each burst (owner, step count, mode, DONE,
// latency) from the arbitration rules and queues it; a monitor rebuilds bursts from the pins.
module tb_oddeven_arbiter;

  localparam int unsigned LW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          REQ0, MODE0, REQ1, MODE1;
  logic [LW-1:0] LEN0, LEN1;
  logic          GNT0, GNT1, DONE0, DONE1, K, STEP, CNT_RST_N, BUSY;

  oddeven_arbiter #(.LEN_W(LW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ0      (REQ0),
    .MODE0     (MODE0),
    .LEN0      (LEN0),
    .REQ1      (REQ1),
    .MODE1     (MODE1),
    .LEN1      (LEN1),
    .GNT0      (GNT0),
    .GNT1      (GNT1),
    .DONE0     (DONE0),
    .DONE1     (DONE1),
    .K         (K),
    .STEP      (STEP),
    .CNT_RST_N (CNT_RST_N),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int owner;
    int steps;
    int k;
    int done;
    int lat;
  } burst_t;

  burst_t exp_q[$];
  int     total = 0;
  int     bad = 0;
  int     ptr_m = 0;  // requester favoured on a tie

`ifdef ODDEVEN_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input int o, input int s, input int k, input int d);
    burst_t b;
    b.owner = o;
    b.steps = s;
    b.k     = k;
    b.done  = d;
    b.lat   = s + 2;
    exp_q.push_back(b);
  endtask

  // ---------------- monitor ----------------
  initial begin
    bit active = 0;
    int owner = 0, idx = 0, steps = 0, kf = 0, kchg = 0, dn = 0, lat = 0;
    burst_t e;
    forever begin
      @(negedge CLK);
      if (RST) begin
        active = 0;
      end else begin
        check("gnt_exclusive", int'(GNT0 & GNT1), 0);
        check("busy_vs_gnt", int'(BUSY), int'(GNT0 | GNT1));
        check("done0_without_gnt0", int'(DONE0 & ~GNT0), 0);
        check("done1_without_gnt1", int'(DONE1 & ~GNT1), 0);
        check("step_without_gnt", int'(STEP & ~(GNT0 | GNT1)), 0);
        if (GNT0 | GNT1) begin
          if (!active) begin
            active = 1; owner = int'(GNT1); idx = 1; steps = 0;
            kf = int'(K); kchg = 0; dn = 0; lat = 0;
          end else begin
            idx++;
          end
          check("cnt_rst_n_in_burst", int'(CNT_RST_N), (idx == 1) ? 0 : 1);
          check("owner_stable", int'(GNT1), owner);
          if (STEP) begin
            steps++;
            if (int'(K) != kf) kchg = 1;
          end
          if (DONE0 | DONE1) begin
            dn++;
            lat = idx;
          end
        end else begin
          check("cnt_rst_n_idle", int'(CNT_RST_N), 1);
          if (active) begin
            active = 0;
            if (exp_q.size() == 0) begin
              check("unexpected_burst", 1, 0);
            end else begin
              e = exp_q.pop_front();
              check("burst_owner", owner, e.owner);
              check("burst_steps", steps, e.steps);
              check("burst_k", kf, e.k);
              check("burst_k_constant", kchg, 0);
              check("burst_done", dn, e.done);
              if (e.done != 0) check("burst_latency", lat, e.lat);
            end
          end
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic set_req(input int r, input bit v);
    if (r == 0) REQ0 = v; else REQ1 = v;
  endtask

  task automatic set_cfg(input int r, input bit m, input int len);
    if (r == 0) begin MODE0 = m; LEN0 = LW'(len); end
    else begin MODE1 = m; LEN1 = LW'(len); end
  endtask

  task automatic wait_gnt(input int r);
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge CLK);
      if ((r == 0) ? GNT0 : GNT1) ok = 1;
    end
    check("gnt_wait_in_budget", int'(ok), 1);
  endtask

  task automatic wait_done(input int r, input bit toggle);
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge CLK);
      if ((r == 0) ? DONE0 : DONE1) ok = 1;
      else if (toggle) begin
        if (r == 0) begin MODE0 = ~MODE0; LEN0 = LW'($urandom); end
        else begin MODE1 = ~MODE1; LEN1 = LW'($urandom); end
      end
    end
    check("done_wait_in_budget", int'(ok), 1);
  endtask

  task automatic check_reset_vals();
    check("rst_gnt0", int'(GNT0), 0);
    check("rst_gnt1", int'(GNT1), 0);
    check("rst_done0", int'(DONE0), 0);
    check("rst_done1", int'(DONE1), 0);
    check("rst_k", int'(K), 0);
    check("rst_step", int'(STEP), 0);
    check("rst_busy", int'(BUSY), 0);
    check("rst_cnt_rst_n", int'(CNT_RST_N), 1);
  endtask

  // ---------------- scenarios ----------------
  task automatic single(input int r, input bit m, input int len, input bit toggle);
    set_cfg(r, m, len);
    set_req(r, 1'b1);
    push(r, len, int'(m), 1);
    ptr_m = 1 - r;
    wait_gnt(r);
    wait_done(r, toggle);
    set_req(r, 1'b0);
    @(negedge CLK);
  endtask

  // Both requesters held until n bursts have completed.
  task automatic both(input int n);
    int w;
    int cnt = 0;
    for (int i = 0; i < n; i++) begin
      w = PRIO ? 0 : ptr_m;
      push(w, (w == 0) ? int'(LEN0) : int'(LEN1), (w == 0) ? int'(MODE0) : int'(MODE1), 1);
      ptr_m = 1 - w;
    end
    REQ0 = 1'b1;
    REQ1 = 1'b1;
    for (int i = 0; i < n * 40 && cnt < n; i++) begin
      @(negedge CLK);
      if (DONE0 | DONE1) cnt++;
    end
    check("both_done_in_budget", cnt, n);
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    @(negedge CLK);
  endtask

  // Owner r drops its request after k steps while the other requester waits.
  task automatic abandon(input int r, input bit m, input int len, input int k,
                         input bit om, input int olen);
    int o = 1 - r;
    int s = 0;
    set_cfg(r, m, len);
    set_cfg(o, om, olen);
    set_req(r, 1'b1);
    push(r, k, int'(m), 0);
    wait_gnt(r);
    set_req(o, 1'b1);
    push(o, olen, int'(om), 1);
    ptr_m = r;
    for (int i = 0; i < 40 && s < k; i++) begin
      @(negedge CLK);
      if (STEP) s++;
    end
    check("abandon_steps_reached", s, k);
    set_req(r, 1'b0);
    @(negedge CLK);
    check("abandon_step_low", int'(STEP), 0);
    check("abandon_busy_low", int'(BUSY), 0);
    wait_done(o, 1'b0);
    set_req(o, 1'b0);
    @(negedge CLK);
  endtask

  task automatic reset_mid_run();
    int s = 0;
    set_cfg(0, 1'b1, 10);
    REQ0 = 1'b1;
    wait_gnt(0);
    for (int i = 0; i < 40 && s < 2; i++) begin
      @(negedge CLK);
      if (STEP) s++;
    end
    #3 RST = 1'b1;
    #1 check_reset_vals();
    REQ0 = 1'b0;
    ptr_m = 0;
    @(negedge CLK);
    #2 RST = 1'b0;
    @(negedge CLK);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int sel, r, len, k;
    RST = 1'b1;
    REQ0 = 1'b0; REQ1 = 1'b0; MODE0 = 1'b0; MODE1 = 1'b0; LEN0 = '0; LEN1 = '0;
    #1 check_reset_vals();
    @(negedge CLK);
    #2 RST = 1'b0;
    @(negedge CLK);

    single(0, 1'b1, 3, 1'b0);
    set_cfg(0, 1'b0, 2);
    set_cfg(1, 1'b1, 2);
    both(4);
    single(1, 1'b1, 0, 1'b0);
    abandon(0, 1'b1, 5, 2, 1'b0, 3);
    reset_mid_run();
    single(1, 1'b0, 4, 1'b0);
    single(0, 1'b1, 15, 1'b1);

    for (int it = 0; it < 30; it++) begin
      sel = $urandom_range(0, 2);
      r = $urandom_range(0, 1);
      if (sel == 0) begin
        single(r, 1'($urandom), $urandom_range(0, 15), 1'($urandom));
      end else if (sel == 1) begin
        set_cfg(0, 1'($urandom), $urandom_range(0, 6));
        set_cfg(1, 1'($urandom), $urandom_range(0, 6));
        both($urandom_range(1, 4));
      end else begin
        len = $urandom_range(1, 8);
        k = $urandom_range(0, len - 1);
        abandon(r, 1'($urandom), len, k, 1'($urandom), $urandom_range(0, 6));
      end
    end

    repeat (3) @(negedge CLK);
    check("expected_queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
